move_encoder: RTL and testbench
===============================

// Module: move_encoder
// PURPOSE
//  Converts the nine cell push-buttons of the tic-tac-toe board into a registered cell index 0..8.
//  Sits between the board keypad and the cell-enable decoder, whose 9-bit sel input is driven by
//  sel. It synchronises and debounces the buttons, rejects multi-press and occupied-cell moves,
//  holds each move until the game controller acknowledges it, and waits for release before rearming.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable cycles needed to accept a press or a release (>=1)
//  SEL_W            9  width of sel, matching the decoder select input
// PORTS
//  clk          in   1      system clock, all logic rising-edge
//  rst          in   1      synchronous, active-high reset
//  btn          in   9      raw buttons, btn[i]=1 pressed; btn[0]=cell 1 .. btn[8]=cell 9; asynchronous
//  occupied     in   9      occupied[i]=1 if cell i+1 is already taken; synchronous to clk
//  sel_ack      in   1      controller consumed the move; only honoured while sel_valid=1
//  sel          out  SEL_W  cell index 0..8, zero-extended; stable whenever sel_valid=1
//  sel_valid    out  1      move pending; held high until sel_ack
//  err_multi    out  1      1-cycle pulse: more than one button held at evaluation
//  err_occupied out  1      1-cycle pulse: a single button was pressed on an occupied cell
// BEHAVIOUR
//  - Reset: sel=0, sel_valid=0, err_multi=0, err_occupied=0, sync flops=0, counter=0, state=IDLE.
//    Reset mid-operation aborts any press or pending move. A button still held after reset counts as
//    a new press.
//  - btn passes through a 2-flop synchroniser giving btn_s. Only btn_s is used downstream.
//  - Mask register cap[8:0] and counter cnt are wide enough for DEBOUNCE_CYCLES.
//  - IDLE: if btn_s!=0, cap<=btn_s, cnt<=0, go to DEBOUNCE.
//  - DEBOUNCE: if btn_s!=cap, go to IDLE, discarding the press.
//    Otherwise cnt<=cnt+1. On the cycle where cnt==DEBOUNCE_CYCLES-1, evaluate cap:
//      popcount(cap)>1          -> err_multi=1 for 1 cycle, go to RELEASE.
//      one-hot cap & occupied   -> err_occupied=1 for 1 cycle, go to RELEASE.
//      one-hot cap, cell free   -> sel<=index of set bit, sel_valid<=1, go to VALID.
//    occupied is sampled only in this evaluation cycle. Multi-press is checked before occupied.
//  - VALID: sel and sel_valid are held. Button changes are ignored.
//    When sel_ack=1, sel_valid<=0 on the next edge and the state goes to RELEASE.
//    sel keeps its last value; consumers qualify sel with sel_valid.
//  - RELEASE: counts consecutive cycles with btn_s==0. Any nonzero btn_s clears the count.
//    After DEBOUNCE_CYCLES zero cycles, go to IDLE. This gives exactly one move per press.
//  - Latency: with btn high and stable from edge 0, btn_s is valid at edge 1 and DEBOUNCE is
//    entered at edge 2. sel_valid rises at edge DEBOUNCE_CYCLES+2 (default: edge 6).
//    Error pulses appear at the same edge.
//  - sel_ack while sel_valid=0 is ignored. No state and no error is affected.
//  - Error outputs are never high together. Neither error is ever high while sel_valid=1.
//  - sel never exceeds 8.
// TESTING
//  1 Reset: assert rst 2 cycles with btn=9'h010 -> all outputs 0.
//    After release, the held btn yields sel=4, sel_valid=1 at edge 6 after rst drops.
//  2 Single press: btn=9'h004, occupied=0 -> sel=2, sel_valid=1 at edge 6. Stays high until sel_ack.
//    Drops 1 cycle after ack. No second move while btn stays high.
//  3 Bounce: btn=9'h001 for 2 cycles, 0 for 1, then held -> no sel_valid until 4 stable btn_s
//    cycles, then sel=0.
//  4 Multi-press: btn=9'h101 -> err_multi pulses 1 cycle, sel_valid stays 0.
//    After btn=0 for 4 cycles, btn=9'h100 -> sel=8.
//  5 Occupied: occupied=9'h020, btn=9'h020 -> err_occupied pulse, sel_valid=0.
//    Same press with occupied=0 -> sel=5.
//  6 Ack corner cases: sel_ack held high before a press -> sel_valid still rises, then clears next
//    cycle. rst asserted during VALID -> sel_valid=0, state IDLE.

Source files
------------

// File: rtl/move_encoder.sv
// Tic-tac-toe keypad encoder: turns nine cell buttons into a registered
// cell index 0..8 with debounce, multi-press and occupied-cell rejection.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   btn[8:0]      raw asynchronous buttons, btn[i] = cell i+1
//   occupied[8:0] cell already taken, synchronous to clk
//   sel_ack       controller consumed the pending move
//   sel           registered cell index, zero-extended to SEL_W
//   sel_valid     move pending, held until sel_ack
//   err_multi     1-cycle pulse, more than one button held
//   err_occupied  1-cycle pulse, single press on a taken cell
module move_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SEL_W           = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       btn,
  input  logic [8:0]       occupied,
  input  logic             sel_ack,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             err_multi,
  output logic             err_occupied
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    VALID,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       sync_q;
  logic [8:0]       btn_s_q;
  logic [8:0]       cap_q, cap_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             errm_q, errm_d;
  logic             erro_q, erro_d;

  logic [3:0]       pop;
  logic [3:0]       idx;

  // Bit count and highest set index of the captured mask; idx is only
  // used when the mask is one-hot, so "highest" is simply "the" bit.
  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < 9; i++) begin
      pop = pop + 4'(cap_q[i]);
      if (cap_q[i]) idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    errm_d  = 1'b0;
    erro_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s_q != '0) begin
          cap_d   = btn_s_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (btn_s_q != cap_q) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          // Evaluation cycle: multi-press wins over occupied.
          state_d = RELEASE;
          cnt_d   = '0;
          if (pop > 4'd1) begin
            errm_d = 1'b1;
          end else if ((cap_q & occupied) != '0) begin
            erro_d = 1'b1;
          end else begin
            sel_d   = SEL_W'(idx);
            valid_d = 1'b1;
            state_d = VALID;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      VALID: begin
        if (sel_ack) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Rearm only after a full run of released cycles.
        if (btn_s_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      btn_s_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      errm_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= btn;
      btn_s_q <= sync_q;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      errm_q  <= errm_d;
      erro_q  <= erro_d;
    end
  end

  assign sel          = sel_q;
  assign sel_valid    = valid_q;
  assign err_multi    = errm_q;
  assign err_occupied = erro_q;

endmodule

// File: tb/tb_move_encoder.sv
// Self-checking bench for move_encoder: directed steps plus random
// presses checked against a transaction-level outcome model.
module tb_move_encoder;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [8:0] btn;
  logic [8:0] occupied;
  logic       sel_ack;
  logic [8:0] sel;
  logic       sel_valid;
  logic       err_multi;
  logic       err_occupied;

  int n_cmp;
  int n_err;

  move_encoder #(
    .DEBOUNCE_CYCLES(D),
    .SEL_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .occupied(occupied),
    .sel_ack(sel_ack),
    .sel(sel),
    .sel_valid(sel_valid),
    .err_multi(err_multi),
    .err_occupied(err_occupied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Caller has just driven a stable press b (after some edge -1).
  // Outcome is decided at edge D+2; before that nothing is visible.
  task automatic check_outcome(input logic [8:0] b,
                               input logic [8:0] occ,
                               input string tag,
                               input int rel);
    int kind;
    int idx;
    int k;
    if ($countones(b) > 1) kind = 1;
    else if ((b & occ) != 9'd0) kind = 2;
    else kind = 0;
    idx = (kind == 0) ? $clog2(b) : 0;
    step(D + 2);
    chk({tag, ":early_v"}, 32'(sel_valid), 32'(0));
    chk({tag, ":early_e"},
        32'({err_multi, err_occupied}), 32'(0));
    step(1);
    chk({tag, ":valid"}, 32'(sel_valid), 32'(kind == 0));
    chk({tag, ":emulti"}, 32'(err_multi), 32'(kind == 1));
    chk({tag, ":eocc"}, 32'(err_occupied), 32'(kind == 2));
    if (kind == 0) begin
      chk({tag, ":sel"}, 32'(sel), 32'(idx));
      k = $urandom_range(0, 4);
      repeat (k) begin
        btn = 9'($urandom_range(0, 511));
        step(1);
        chk({tag, ":hold_v"}, 32'(sel_valid), 32'(1));
        chk({tag, ":hold_sel"}, 32'(sel), 32'(idx));
      end
      btn = b;
      sel_ack = 1'b1;
      step(1);
      sel_ack = 1'b0;
      chk({tag, ":ack_v"}, 32'(sel_valid), 32'(0));
      chk({tag, ":ack_sel"}, 32'(sel), 32'(idx));
    end else begin
      step(1);
      chk({tag, ":pulse_e"},
          32'({err_multi, err_occupied}), 32'(0));
      chk({tag, ":pulse_v"}, 32'(sel_valid), 32'(0));
    end
    step(8);
    chk({tag, ":held_v"}, 32'(sel_valid), 32'(0));
    chk({tag, ":held_e"},
        32'({err_multi, err_occupied}), 32'(0));
    btn = 9'd0;
    step(rel);
  endtask

  task automatic expect_move(input logic [8:0] b,
                             input logic [8:0] occ,
                             input string tag,
                             input int rel);
    btn = b;
    occupied = occ;
    check_outcome(b, occ, tag, rel);
  endtask

  initial begin
    logic [8:0] rb;
    logic [8:0] ro;
    n_cmp = 0;
    n_err = 0;
    sel_ack = 1'b0;
    occupied = 9'd0;
    btn = 9'h010;
    rst = 1'b1;

    // Reset with a button held
    step(2);
    chk("rst:sel", 32'(sel), 32'(0));
    chk("rst:valid", 32'(sel_valid), 32'(0));
    chk("rst:emulti", 32'(err_multi), 32'(0));
    chk("rst:eocc", 32'(err_occupied), 32'(0));
    rst = 1'b0;
    expect_move(9'h010, 9'h000, "rst_held", 10);

    // Single press
    expect_move(9'h004, 9'h000, "single", 10);

    // Bounce: 2 high, 1 low, then held
    btn = 9'h001;
    step(2);
    btn = 9'h000;
    step(1);
    btn = 9'h001;
    check_outcome(9'h001, 9'h000, "bounce", 10);

    // Multi-press then exact minimum release
    expect_move(9'h101, 9'h000, "multi", D);
    expect_move(9'h100, 9'h000, "multi_next", 10);

    // Occupied then free
    expect_move(9'h020, 9'h020, "occ", 10);
    expect_move(9'h020, 9'h000, "occ_free", 10);

    // Ack held before the press
    sel_ack = 1'b1;
    btn = 9'h080;
    step(D + 2);
    chk("ackpre:early_v", 32'(sel_valid), 32'(0));
    step(1);
    chk("ackpre:valid", 32'(sel_valid), 32'(1));
    chk("ackpre:sel", 32'(sel), 32'(7));
    step(1);
    chk("ackpre:clear", 32'(sel_valid), 32'(0));
    sel_ack = 1'b0;
    btn = 9'h000;
    step(10);

    // Reset during a pending move, button kept held
    btn = 9'h008;
    step(D + 3);
    chk("rstv:valid", 32'(sel_valid), 32'(1));
    chk("rstv:sel", 32'(sel), 32'(3));
    rst = 1'b1;
    step(1);
    chk("rstv:v0", 32'(sel_valid), 32'(0));
    chk("rstv:sel0", 32'(sel), 32'(0));
    rst = 1'b0;
    check_outcome(9'h008, 9'h000, "rstv_again", 10);

    // Random presses
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7)
        rb = 9'(1 << $urandom_range(0, 8));
      else
        rb = 9'($urandom_range(1, 511));
      if ($urandom_range(0, 1) == 0)
        ro = 9'd0;
      else
        ro = 9'($urandom_range(0, 511));
      expect_move(rb, ro, "rand", 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
